// File: rtl/pulse_cmd_pkg.sv
// Shared types and constants for the pulse-parameter command register file.
package pulse_cmd_pkg;

  typedef enum logic [1:0] {
    ST_RECV    = 2'd0,
    ST_EXEC    = 2'd1,
    ST_SEND    = 2'd2,
    ST_WAIT_TX = 2'd3
  } state_e;

  localparam logic [7:0] NAK_BYTE = 8'hEE;
  localparam int         READ_BIT = 7;

  localparam int DEF_NUM_REGS = 8;
  localparam int DEF_DATA_W   = 32;

  // reg0 = 200, reg1 = 201000, reg2 = reg3 = 30, remaining registers zero
  localparam logic [DEF_NUM_REGS*DEF_DATA_W-1:0] DEF_RST_VALS = {
    32'd0, 32'd0, 32'd0, 32'd0, 32'd30, 32'd30, 32'd201000, 32'd200
  };

endpackage

// File: rtl/pulse_cmd_tx_seq.sv
// Reply sequencer: walks a loaded reply buffer LSB byte first, one byte per
// tx_start, pausing for the UART busy flag between bytes.
module pulse_cmd_tx_seq
  import pulse_cmd_pkg::*;
#(
  parameter int DATA_BYTES = 4
) (
  input  logic                              clk_i,
  input  logic                              rst_i,
  input  logic                              load_i,
  input  logic [DATA_BYTES*8+7:0]           buf_i,
  input  logic [$clog2(DATA_BYTES+2)-1:0]   len_i,
  input  logic                              tx_busy_i,
  output logic                              tx_start_o,
  output logic [7:0]                        tx_byte_o,
  output logic                              busy_o
);

  localparam int BUF_W = DATA_BYTES*8 + 8;
  localparam int CNT_W = $clog2(DATA_BYTES+2);

  state_e           state_q;
  logic             guard_q;
  logic [CNT_W-1:0] rem_q;
  logic [BUF_W-1:0] buf_q;
  logic [7:0]       byte_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= ST_RECV;
      guard_q <= 1'b0;
      rem_q   <= '0;
      byte_q  <= '0;
    end else begin
      case (state_q)
        ST_SEND: begin
          if (!tx_busy_i) begin
            state_q <= ST_WAIT_TX;
            guard_q <= 1'b1;
            rem_q   <= rem_q - 1'b1;
            buf_q   <= {8'h00, buf_q[BUF_W-1:8]};
          end
        end
        ST_WAIT_TX: begin
          // first cycle ignores tx_busy so the UART has time to raise it
          if (guard_q) begin
            guard_q <= 1'b0;
          end else if (!tx_busy_i) begin
            if (rem_q == '0) begin
              state_q <= ST_RECV;
            end else begin
              byte_q  <= buf_q[7:0];
              state_q <= ST_SEND;
            end
          end
        end
        default: begin
          if (load_i) begin
            buf_q   <= buf_i;
            rem_q   <= len_i;
            byte_q  <= buf_i[7:0];
            state_q <= ST_SEND;
          end
        end
      endcase
    end
  end

  // gated by the live busy flag so a request can never overlap a busy UART
  assign tx_start_o = (state_q == ST_SEND) && !tx_busy_i;
  assign tx_byte_o  = byte_q;
  assign busy_o     = (state_q != ST_RECV);

endmodule

// File: rtl/pulse_cmd_regfile.sv
// UART-framed register file: collects payload+control frames, writes or reads
// a pulse-parameter register and returns a checksum/data/NAK reply.
module pulse_cmd_regfile
  import pulse_cmd_pkg::*;
#(
  parameter int DATA_BYTES  = 4,
  parameter int NUM_REGS    = 8,
  parameter int TIMEOUT_CYC = 2010000,
  parameter logic [NUM_REGS*DATA_BYTES*8-1:0] RST_VALS =
    (NUM_REGS*DATA_BYTES*8)'(DEF_RST_VALS)
) (
  input  logic                             clk,
  input  logic                             rst,
  input  logic                             rx_valid,
  input  logic [7:0]                       rx_byte,
  input  logic                             tx_busy,
  output logic                             tx_start,
  output logic [7:0]                       tx_byte,
  output logic [NUM_REGS*DATA_BYTES*8-1:0] regs,
  output logic [NUM_REGS-1:0]              upd_strobe,
  output logic                             cmd_err,
  output logic                             frame_to
);

  localparam int DATA_W = 8*DATA_BYTES;
  localparam int BUF_W  = DATA_W + 8;
  localparam int CNT_W  = $clog2(DATA_BYTES+2);
  localparam int TMR_W  = $clog2(TIMEOUT_CYC+1);
  localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DATA_BYTES);
  localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT_CYC-1);

  state_e                     state_q;
  logic [CNT_W-1:0]           cnt_q;
  logic [TMR_W-1:0]           tmr_q;
  logic [DATA_W-1:0]          pay_q;
  logic [DATA_W-1:0]          pay_d;
  logic [7:0]                 ctrl_q;
  logic [NUM_REGS*DATA_W-1:0] regs_q;
  logic [NUM_REGS-1:0]        upd_q;
  logic                       err_q;
  logic                       to_q;

  logic                       seq_busy;
  logic                       rx_ok;
  logic                       load;
  logic [6:0]                 idx;
  logic                       is_rd;
  logic                       idx_ok;
  logic [DATA_W-1:0]          rd_data;
  logic [BUF_W-1:0]           reply_buf;
  logic [CNT_W-1:0]           reply_len;
  logic [DATA_W+7:0]          shift_tmp;

  function automatic logic [7:0] byte_sum(input logic [DATA_W-1:0] w);
    logic [7:0] s;
    s = 8'h00;
    for (int i = 0; i < DATA_BYTES; i++) s = s + w[i*8 +: 8];
    return s;
  endfunction

  always_comb begin
    // payload arrives LSB first, so new bytes enter at the top and shift down
    shift_tmp = {rx_byte, pay_q};
    pay_d     = shift_tmp[DATA_W+7:8];

    idx    = ctrl_q[6:0];
    is_rd  = ctrl_q[READ_BIT];
    idx_ok = (idx < 7'(NUM_REGS));

    rd_data = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (idx == 7'(i)) rd_data = regs_q[i*DATA_W +: DATA_W];
    end

    reply_buf = '0;
    reply_len = CNT_W'(1);
    if (!idx_ok) begin
      reply_buf[7:0] = NAK_BYTE;
    end else if (is_rd) begin
      reply_buf = {byte_sum(rd_data), rd_data};
      reply_len = CNT_W'(DATA_BYTES+1);
    end else begin
      reply_buf[7:0] = byte_sum(pay_q);
    end

    rx_ok = rx_valid && (state_q == ST_RECV) && !seq_busy;
    load  = (state_q == ST_EXEC);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_RECV;
      cnt_q   <= '0;
      tmr_q   <= '0;
      regs_q  <= RST_VALS;
      upd_q   <= '0;
      err_q   <= 1'b0;
      to_q    <= 1'b0;
    end else begin
      upd_q <= '0;
      err_q <= 1'b0;
      to_q  <= 1'b0;
      case (state_q)
        ST_EXEC: begin
          state_q <= ST_RECV;
          for (int i = 0; i < NUM_REGS; i++) begin
            if (!is_rd && idx == 7'(i)) begin
              regs_q[i*DATA_W +: DATA_W] <= pay_q;
              upd_q[i]                   <= 1'b1;
            end
          end
          if (!idx_ok) err_q <= 1'b1;
        end
        default: begin
          state_q <= ST_RECV;
          // an accepted byte always wins over a timeout in the same cycle
          if (rx_ok) begin
            tmr_q <= '0;
            if (cnt_q == CNT_FULL) begin
              ctrl_q  <= rx_byte;
              cnt_q   <= '0;
              state_q <= ST_EXEC;
            end else begin
              pay_q <= pay_d;
              cnt_q <= cnt_q + 1'b1;
            end
          end else if (cnt_q != '0) begin
            if (tmr_q == TMR_LAST) begin
              cnt_q <= '0;
              tmr_q <= '0;
              to_q  <= 1'b1;
            end else begin
              tmr_q <= tmr_q + 1'b1;
            end
          end
        end
      endcase
    end
  end

  pulse_cmd_tx_seq #(
    .DATA_BYTES(DATA_BYTES)
  ) u_tx_seq (
    .clk_i      (clk),
    .rst_i      (rst),
    .load_i     (load),
    .buf_i      (reply_buf),
    .len_i      (reply_len),
    .tx_busy_i  (tx_busy),
    .tx_start_o (tx_start),
    .tx_byte_o  (tx_byte),
    .busy_o     (seq_busy)
  );

  assign regs       = regs_q;
  assign upd_strobe = upd_q;
  assign cmd_err    = err_q;
  assign frame_to   = to_q;

endmodule
